plane_scan_sequencer: RTL and testbench

Upstream controller for the LED-cube shift-register loader. It walks the planes of the current animation frame and fetches one plane word per plane from frame memory. It hands each word to the loader through a start/done handshake, then blanks the plane drivers, latches the new word and enables the matching plane for a fixed dwell. Frame advance requests are deferred to the plane-0 boundary so a frame never tears.

---
 rtl/plane_scan_if.sv | 33 +++
 rtl/plane_scan_sequencer.sv | 165 ++++++++++++++++
 tb/tb_plane_scan_sequencer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/plane_scan_if.sv
// plane_scan_if: bundles the frame-memory, loader and plane-driver signals
// of the LED-cube plane scan sequencer.
// master = sequencer side, slave = memory/loader/driver side.
`timescale 1ns/1ps
interface plane_scan_if #(
   parameter int NUM_PLANES = 7,
   parameter int NUM_FRAMES = 7,
   parameter int WORD_WIDTH = 56,
   parameter int ADDR_WIDTH = 16
);
   localparam int FI_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

   logic                  frame_tick;
   logic [ADDR_WIDTH-1:0] rom_addr;
   logic [WORD_WIDTH-1:0] rom_data;
   logic [WORD_WIDTH-1:0] load_data;
   logic                  shift_start;
   logic                  shift_done;
   logic                  latch;
   logic [NUM_PLANES-1:0] plane_en;
   logic                  blank;
   logic [FI_W-1:0]       frame_index;

   modport master (
      input  frame_tick, rom_data, shift_done,
      output rom_addr, load_data, shift_start, latch, plane_en, blank, frame_index
   );

   modport slave (
      output frame_tick, rom_data, shift_done,
      input  rom_addr, load_data, shift_start, latch, plane_en, blank, frame_index
   );
endinterface

// File: rtl/plane_scan_sequencer.sv
// plane_scan_sequencer: walks the planes of the current frame, fetches one
// word per plane from synchronous frame memory, hands it to the shift loader,
// then blanks, latches and lights the plane for a fixed dwell. Frame advance
// requests are held until the plane-0 boundary so a frame never tears.
// Optional build macro: PLANE_SCAN_INVERT_EN stores ~rom_data into load_data
// (for sink-driven column hardware); undefined stores rom_data unchanged.
`timescale 1ns/1ps
module plane_scan_sequencer #(
   parameter int NUM_PLANES   = 7,
   parameter int NUM_FRAMES   = 7,
   parameter int WORD_WIDTH   = 56,
   parameter int ADDR_WIDTH   = 16,
   parameter int DWELL_CYCLES = 1000,
   parameter int BLANK_CYCLES = 4
) (
   input logic          clk,
   input logic          reset,
   plane_scan_if.master bus
);
   localparam int PI_W = (NUM_PLANES > 1) ? $clog2(NUM_PLANES) : 1;
   localparam int FI_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
   localparam int DW_W = $clog2(DWELL_CYCLES) + 1;
   localparam int BL_W = $clog2(BLANK_CYCLES) + 1;

   typedef enum logic [2:0] {
      FETCH_A = 3'd0,
      FETCH_B = 3'd1,
      SHIFT   = 3'd2,
      BLANK   = 3'd3,
      LATCH   = 3'd4,
      DWELL   = 3'd5
   } state_t;

   state_t                state_reg, state_next;
   logic [PI_W-1:0]       plane_index_reg, plane_index_next;
   logic [FI_W-1:0]       frame_index_reg, frame_index_next;
   logic                  pending_reg, pending_next;
   logic [WORD_WIDTH-1:0] load_data_reg, load_data_next;
   logic                  shift_start_reg, shift_start_next;
   logic [NUM_PLANES-1:0] plane_en_reg, plane_en_next;
   logic [DW_W-1:0]       dwell_cnt_reg, dwell_cnt_next;
   logic [BL_W-1:0]       blank_cnt_reg, blank_cnt_next;
   logic [NUM_PLANES-1:0] plane_onehot;
   logic [WORD_WIDTH-1:0] capture_word;
   logic                  advance_req;

   // One-hot decode of the current plane, used when the plane is lit.
   generate
      for (genvar gi = 0; gi < NUM_PLANES; gi++) begin : g_onehot
         assign plane_onehot[gi] = (plane_index_reg == PI_W'(gi));
      end
   endgenerate

   // Word polarity at capture time.
`ifdef PLANE_SCAN_INVERT_EN
   assign capture_word = ~bus.rom_data;
`else
   assign capture_word = bus.rom_data;
`endif

   // A tick arriving on the wrap cycle itself is honoured at that wrap.
   assign advance_req = pending_reg | bus.frame_tick;

   // Address tracks the registered indices; it is already valid in FETCH_A.
   assign bus.rom_addr    = ADDR_WIDTH'(frame_index_reg) * ADDR_WIDTH'(NUM_PLANES)
                          + ADDR_WIDTH'(plane_index_reg);
   assign bus.load_data   = load_data_reg;
   assign bus.shift_start = shift_start_reg;
   assign bus.latch       = (state_reg == LATCH);
   assign bus.plane_en    = plane_en_reg;
   assign bus.blank       = ~|plane_en_reg;
   assign bus.frame_index = frame_index_reg;

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= FETCH_A;
         plane_index_reg <= '0;
         frame_index_reg <= '0;
         pending_reg     <= 1'b0;
         load_data_reg   <= '0;
         shift_start_reg <= 1'b0;
         plane_en_reg    <= '0;
         dwell_cnt_reg   <= '0;
         blank_cnt_reg   <= '0;
      end else begin
         state_reg       <= state_next;
         plane_index_reg <= plane_index_next;
         frame_index_reg <= frame_index_next;
         pending_reg     <= pending_next;
         load_data_reg   <= load_data_next;
         shift_start_reg <= shift_start_next;
         plane_en_reg    <= plane_en_next;
         dwell_cnt_reg   <= dwell_cnt_next;
         blank_cnt_reg   <= blank_cnt_next;
      end
   end

   // Next-state logic: fetch, shift, blank, latch, dwell; the previous plane
   // stays lit until the shift completes so shifting overlaps display time.
   always_comb begin
      state_next       = state_reg;
      plane_index_next = plane_index_reg;
      frame_index_next = frame_index_reg;
      pending_next     = advance_req;
      load_data_next   = load_data_reg;
      shift_start_next = 1'b0;
      plane_en_next    = plane_en_reg;
      dwell_cnt_next   = dwell_cnt_reg;
      blank_cnt_next   = blank_cnt_reg;

      case (state_reg)
         FETCH_A: begin
            state_next = FETCH_B;
         end
         FETCH_B: begin
            load_data_next   = capture_word;
            shift_start_next = 1'b1;
            state_next       = SHIFT;
         end
         SHIFT: begin
            if (bus.shift_done) begin
               state_next     = BLANK;
               plane_en_next  = '0;
               blank_cnt_next = '0;
            end
         end
         BLANK: begin
            if (blank_cnt_reg == BL_W'(BLANK_CYCLES - 1)) begin
               state_next = LATCH;
            end else begin
               blank_cnt_next = blank_cnt_reg + BL_W'(1);
            end
         end
         LATCH: begin
            state_next     = DWELL;
            plane_en_next  = plane_onehot;
            dwell_cnt_next = '0;
         end
         DWELL: begin
            if (dwell_cnt_reg == DW_W'(DWELL_CYCLES - 1)) begin
               state_next = FETCH_A;
               if (plane_index_reg == PI_W'(NUM_PLANES - 1)) begin
                  plane_index_next = '0;
                  if (advance_req) begin
                     pending_next = 1'b0;
                     if (frame_index_reg == FI_W'(NUM_FRAMES - 1)) begin
                        frame_index_next = '0;
                     end else begin
                        frame_index_next = frame_index_reg + FI_W'(1);
                     end
                  end
               end else begin
                  plane_index_next = plane_index_reg + PI_W'(1);
               end
            end else begin
               dwell_cnt_next = dwell_cnt_reg + DW_W'(1);
            end
         end
         default: begin
            state_next = FETCH_A;
         end
      endcase
   end
endmodule

// File: tb/tb_plane_scan_sequencer.sv
// tb_plane_scan_sequencer: scoreboard bench. Stimulus queues the expected
// per-plane transaction; a monitor pops and checks it whenever the DUT pulses
// shift_start / latch, and checks reset snapshots when reset is applied.
`timescale 1ns/1ps
module tb_plane_scan_sequencer;
   localparam int NP = 3;
   localparam int NF = 2;
   localparam int WW = 56;
   localparam int AW = 16;
   localparam int DWELL = 5;
   localparam int BLANK = 2;

   typedef struct {
      int            rel;
      int            addr;
      int            frame;
      logic [WW-1:0] data;
      logic [NP-1:0] prev_en;
      logic [NP-1:0] dwell_en;
      int            s_cyc;
      int            latch_dly;
   } txn_t;

   logic clk = 1'b0;
   logic reset;
   logic loader_done = 1'b0;
   logic stray_done = 1'b0;
   int   loader_delay = 3;
   int   sd_cnt = 0;
   int   cyc = 0;
   int   base = 0;
   logic rst_sampled = 1'b0;
   int   checks = 0;
   int   errors = 0;
   txn_t tq[$];
   int   rq[$];
   txn_t cur;
   bit   awaiting = 0;
   bit   dwell_chk = 0;
   bit   hold_bad = 0;
   int   k = 0;

   plane_scan_if #(.NUM_PLANES(NP), .NUM_FRAMES(NF), .WORD_WIDTH(WW), .ADDR_WIDTH(AW)) bus ();

   plane_scan_sequencer #(
      .NUM_PLANES(NP), .NUM_FRAMES(NF), .WORD_WIDTH(WW), .ADDR_WIDTH(AW),
      .DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   assign bus.shift_done = loader_done | stray_done;

   function automatic logic [WW-1:0] rom_word(input int a);
      logic [WW-1:0] w;
      if (a == 0) w = 56'h00FF00FF00FF00;
      else w = 56'h5A000000000000 + WW'(a) * 56'h00010101;
      return w;
   endfunction

   function automatic logic [WW-1:0] exp_word(input int a);
`ifdef PLANE_SCAN_INVERT_EN
      return ~rom_word(a);
`else
      return rom_word(a);
`endif
   endfunction

   // Synchronous ROM: one-cycle read latency.
   always @(posedge clk) bus.rom_data <= rom_word(int'(bus.rom_addr));

   // Cycle counter and the reset value the DUT sampled on this edge.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      rst_sampled <= reset;
   end

   // Loader model: raise shift_done loader_delay cycles after shift_start.
   initial begin
      forever begin
         @(negedge clk);
         loader_done = 1'b0;
         if (sd_cnt > 0) begin
            sd_cnt--;
            if (sd_cnt == 0) loader_done = 1'b1;
         end
         if (bus.shift_start === 1'b1) sd_cnt = loader_delay;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (rel cycle %0d)", name, act, exp, cyc - base);
      end
   endtask

   task automatic add(input int rs, input int addr, input int frame, input int plane,
                      input int prev, input int dly, input bit abort_plane);
      txn_t t;
      t.rel       = rs + 2;
      t.addr      = addr;
      t.frame     = frame;
      t.data      = exp_word(addr);
      t.prev_en   = (prev < 0) ? '0 : NP'(1 << prev);
      t.dwell_en  = NP'(1 << plane);
      t.s_cyc     = dly + 1;
      t.latch_dly = abort_plane ? -1 : dly + 1 + BLANK;
      tq.push_back(t);
   endtask

   task automatic goto(input int rel);
      while (cyc - base < rel) @(negedge clk);
   endtask

   task automatic pulse_tick(input int rel);
      goto(rel);
      bus.frame_tick = 1'b1;
      @(negedge clk);
      bus.frame_tick = 1'b0;
   endtask

   // Monitor: checks reset snapshots, each fetched plane at shift_start,
   // hold behaviour during SHIFT, latch placement and the lit plane.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_sampled) begin
            awaiting = 0;
            dwell_chk = 0;
            if (rq.size() > 0) begin
               void'(rq.pop_front());
               chk("rst_rom_addr", 64'(bus.rom_addr), 64'd0);
               chk("rst_load_data", 64'(bus.load_data), 64'd0);
               chk("rst_shift_start", 64'(bus.shift_start), 64'd0);
               chk("rst_latch", 64'(bus.latch), 64'd0);
               chk("rst_plane_en", 64'(bus.plane_en), 64'd0);
               chk("rst_blank", 64'(bus.blank), 64'd1);
               chk("rst_frame_index", 64'(bus.frame_index), 64'd0);
               $display("txn reset snapshot at cycle %0d", cyc);
            end
         end else begin
            chk("plane_en_onehot0", 64'($countones(bus.plane_en) <= 1), 64'd1);
            chk("blank_vs_plane_en", 64'(bus.blank), 64'(bus.plane_en == '0));
            if (dwell_chk) begin
               chk("dwell_plane_en", 64'(bus.plane_en), 64'(cur.dwell_en));
               dwell_chk = 0;
            end
            if (awaiting) k++;
            if (bus.shift_start === 1'b1) begin
               if (awaiting) begin
                  checks++; errors++;
                  $display("FAIL shift_start_repeat: got second pulse, expected one (rel cycle %0d)", cyc - base);
               end else if (tq.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL shift_start_unexpected: got pulse, expected none (rel cycle %0d)", cyc - base);
               end else begin
                  cur = tq.pop_front();
                  awaiting = 1; k = 0; hold_bad = 0;
                  chk("shift_start_cycle", 64'(cyc - base), 64'(cur.rel));
                  chk("rom_addr", 64'(bus.rom_addr), 64'(cur.addr));
                  chk("frame_index", 64'(bus.frame_index), 64'(cur.frame));
                  chk("load_data", 64'(bus.load_data), 64'(cur.data));
                  $display("txn plane: rel=%0d addr=%0d frame=%0d load_data=%h",
                           cyc - base, bus.rom_addr, bus.frame_index, bus.load_data);
               end
            end
            if (awaiting && k < cur.s_cyc && bus.plane_en !== cur.prev_en) hold_bad = 1;
            if (bus.latch === 1'b1) begin
               if (!awaiting) begin
                  checks++; errors++;
                  $display("FAIL latch_unexpected: got latch, expected none (rel cycle %0d)", cyc - base);
               end else begin
                  chk("latch_delay", 64'(k), 64'(cur.latch_dly));
                  chk("shift_prev_plane_lit", 64'(hold_bad), 64'd0);
                  chk("latch_plane_en", 64'(bus.plane_en), 64'd0);
                  awaiting = 0;
                  dwell_chk = 1;
               end
            end
         end
      end
   end

   // Stimulus: directed scan scenarios with hand-computed plane timeline
   // (14-cycle plane period with S=4).
   initial begin
      reset = 1'b1;
      bus.frame_tick = 1'b0;
      rq.push_back(1);
      // free-running scan, tick in plane-1 dwell, tick in frame 1
      add(0, 0, 0, 0, -1, 3, 0);   add(14, 1, 0, 1, 0, 3, 0);
      add(28, 2, 0, 2, 1, 3, 0);   add(42, 0, 0, 0, 2, 3, 0);
      add(56, 1, 0, 1, 0, 3, 0);   add(70, 2, 0, 2, 1, 3, 0);
      add(84, 3, 1, 0, 2, 3, 0);   add(98, 4, 1, 1, 0, 3, 0);
      add(112, 5, 1, 2, 1, 3, 0);  add(126, 0, 0, 0, 2, 3, 0);
      // tick coincident with wrap, then no second advance
      add(140, 1, 0, 1, 0, 3, 0);  add(154, 2, 0, 2, 1, 3, 0);
      add(168, 3, 1, 0, 2, 3, 0);  add(182, 4, 1, 1, 0, 3, 0);
      add(196, 5, 1, 2, 1, 3, 0);  add(210, 3, 1, 0, 2, 3, 0);
      // 50-cycle shift hold, stray shift_done, reset in BLANK
      add(224, 4, 1, 1, 0, 50, 0); add(285, 5, 1, 2, 1, 3, 0);
      add(299, 3, 1, 0, 2, 3, 0);  add(313, 4, 1, 1, 0, 3, 1);
      // after reset: fresh scan from frame 0, pending dropped
      add(0, 0, 0, 0, -1, 3, 0);   add(14, 1, 0, 1, 0, 3, 0);
      add(28, 2, 0, 2, 1, 3, 0);   add(42, 0, 0, 0, 2, 3, 0);

      repeat (4) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      base = cyc;

      pulse_tick(66);
      pulse_tick(90);
      pulse_tick(167);
      goto(220); loader_delay = 50;
      goto(230); loader_delay = 3;
      goto(300); stray_done = 1'b1;
      @(negedge clk); stray_done = 1'b0;
      pulse_tick(314);
      goto(319);
      rq.push_back(1);
      reset = 1'b1;
      goto(322);
      reset = 1'b0;
      base = cyc;
      goto(53);

      chk("all_planes_seen", 64'(tq.size()), 64'd0);
      chk("reset_snapshots_seen", 64'(rq.size()), 64'd0);
      chk("no_open_plane", 64'(awaiting), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #60000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
